// File: rtl/ioctl_pkg.sv
// Shared definitions for the ioctl download sender and the matching core-side receiver.
package ioctl_pkg;

    localparam int unsigned IOCTL_ADDR_W  = 25;
    localparam int unsigned IOCTL_DATA_W  = 8;
    localparam int unsigned IOCTL_INDEX_W = 8;

    // Width of the shared SETUP/GAP/FINISH down-counter
    localparam int unsigned IOCTL_CNT_W   = 16;

    localparam int unsigned SETUP_CYC_DEF = 4;
    localparam int unsigned GAP_CYC_DEF   = 3;
    localparam int unsigned HOLD_CYC_DEF  = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_FETCH  = 3'd2,
        ST_WRITE  = 3'd3,
        ST_GAP    = 3'd4,
        ST_FINISH = 3'd5
    } ioctl_state_e;

endpackage

// File: rtl/ioctl_dl_sender.sv
// Streams a byte source into the ioctl download port: download window, paced
// single-cycle write strobes with back-pressure, abort and completion pulse.
module ioctl_dl_sender
    import ioctl_pkg::*;
#(
    parameter int unsigned SETUP_CYC = SETUP_CYC_DEF,
    parameter int unsigned GAP_CYC   = GAP_CYC_DEF,
    parameter int unsigned HOLD_CYC  = HOLD_CYC_DEF
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic [IOCTL_INDEX_W-1:0] index_in,
    input  logic [IOCTL_ADDR_W-1:0]  length,
    input  logic                     s_valid,
    input  logic [IOCTL_DATA_W-1:0]  s_data,
    output logic                     s_ready,
    output logic                     ioctl_download,
    output logic                     ioctl_wr,
    output logic [IOCTL_ADDR_W-1:0]  ioctl_addr,
    output logic [IOCTL_DATA_W-1:0]  ioctl_dout,
    output logic [IOCTL_INDEX_W-1:0] ioctl_index,
    input  logic                     ioctl_wait,
    output logic                     busy,
    output logic                     done
);

    ioctl_state_e             r_state, w_state_nxt;
    logic [IOCTL_CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [IOCTL_ADDR_W-1:0]  r_remain, w_remain_nxt;
    logic [IOCTL_ADDR_W-1:0]  r_addr, w_addr_nxt;
    logic [IOCTL_DATA_W-1:0]  r_dout, w_dout_nxt;
    logic [IOCTL_INDEX_W-1:0] r_index, w_index_nxt;
    logic                     r_wr, w_wr_nxt;
    logic                     r_done, w_done_nxt;
    logic                     r_active;
    logic                     r_s_ready;
    logic                     w_cnt_last;

    // Counter has reached its final cycle (also covers a zero-length phase)
    assign w_cnt_last = (r_cnt <= IOCTL_CNT_W'(1));

    // State register
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state and next-register values; abort overrides everything
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_remain_nxt = r_remain;
        w_addr_nxt   = r_addr;
        w_dout_nxt   = r_dout;
        w_index_nxt  = r_index;
        w_wr_nxt     = 1'b0;
        w_done_nxt   = 1'b0;
        if (abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_state_nxt  = ST_SETUP;
                        w_index_nxt  = index_in;
                        w_remain_nxt = length;
                        w_addr_nxt   = '0;
                        w_cnt_nxt    = IOCTL_CNT_W'(SETUP_CYC);
                    end
                end
                ST_SETUP: begin
                    if (w_cnt_last) begin
                        if (r_remain != '0) begin
                            w_state_nxt = ST_FETCH;
                        end else begin
                            w_state_nxt = ST_FINISH;
                            w_cnt_nxt   = IOCTL_CNT_W'(HOLD_CYC);
                        end
                    end else begin
                        w_cnt_nxt = r_cnt - IOCTL_CNT_W'(1);
                    end
                end
                ST_FETCH: begin
                    if (s_valid) begin
                        w_dout_nxt  = s_data;
                        w_state_nxt = ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (!ioctl_wait) begin
                        w_wr_nxt     = 1'b1;
                        w_state_nxt  = ST_GAP;
                        w_cnt_nxt    = IOCTL_CNT_W'(GAP_CYC);
                        w_remain_nxt = r_remain - IOCTL_ADDR_W'(1);
                    end
                end
                ST_GAP: begin
                    // Address moves only when another byte follows, so it never
                    // runs past the last written location
                    if (!ioctl_wait) begin
                        if (w_cnt_last) begin
                            if (r_remain != '0) begin
                                w_state_nxt = ST_FETCH;
                                w_addr_nxt  = r_addr + IOCTL_ADDR_W'(1);
                            end else begin
                                w_state_nxt = ST_FINISH;
                                w_cnt_nxt   = IOCTL_CNT_W'(HOLD_CYC);
                            end
                        end else begin
                            w_cnt_nxt = r_cnt - IOCTL_CNT_W'(1);
                        end
                    end
                end
                ST_FINISH: begin
                    if (w_cnt_last) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt - IOCTL_CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_remain  <= '0;
            r_addr    <= '0;
            r_dout    <= '0;
            r_index   <= '0;
            r_wr      <= 1'b0;
            r_done    <= 1'b0;
            r_active  <= 1'b0;
            r_s_ready <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_remain  <= w_remain_nxt;
            r_addr    <= w_addr_nxt;
            r_dout    <= w_dout_nxt;
            r_index   <= w_index_nxt;
            r_wr      <= w_wr_nxt;
            r_done    <= w_done_nxt;
            r_active  <= (w_state_nxt != ST_IDLE);
            r_s_ready <= (w_state_nxt == ST_FETCH);
        end
    end

    assign s_ready        = r_s_ready;
    assign ioctl_download = r_active;
    assign busy           = r_active;
    assign ioctl_wr       = r_wr;
    assign ioctl_addr     = r_addr;
    assign ioctl_dout     = r_dout;
    assign ioctl_index    = r_index;
    assign done           = r_done;

endmodule
